// File: rtl/pc_redirect_unit_if.sv
// rtl/pc_redirect_unit_if.sv - branch decision in, fetch PC and status out.
// Optional stats counters present when PC_BRANCH_STATS_EN is defined.
interface pc_redirect_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] target;
    logic        is_jalr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        flush;
    logic        misaligned;
`ifdef PC_BRANCH_STATS_EN
    logic [31:0] taken_count;
    logic [7:0]  trap_count;

    modport master (
        output stall, branch_taken, target, is_jalr,
        input  pc, pc_plus4, fetch_valid, flush, misaligned, taken_count, trap_count
    );
    modport slave (
        input  stall, branch_taken, target, is_jalr,
        output pc, pc_plus4, fetch_valid, flush, misaligned, taken_count, trap_count
    );
`else
    modport master (
        output stall, branch_taken, target, is_jalr,
        input  pc, pc_plus4, fetch_valid, flush, misaligned
    );
    modport slave (
        input  stall, branch_taken, target, is_jalr,
        output pc, pc_plus4, fetch_valid, flush, misaligned
    );
`endif
endinterface

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - PC owner: sequential advance, branch redirect with flush, misaligned trap.
// PC_BRANCH_STATS_EN adds taken_count / trap_count.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    pc_redirect_unit_if.slave bus
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, TRAP} state_t;

    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mis_q, mis_d;
    logic        take_ev, trap_ev;
    logic [31:0] pc_plus4;
    logic [31:0] eff_target;

    assign pc_plus4   = pc_q + 32'd4;
    assign eff_target = bus.is_jalr ? {bus.target[31:1], 1'b0} : bus.target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= 4'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        take_ev = 1'b0;
        trap_ev = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (!bus.stall) begin
                    if (bus.branch_taken) begin
                        if (eff_target[1:0] != 2'b00) begin
                            mis_d   = 1'b1;
                            trap_ev = 1'b1;
                            state_d = TRAP;
                        end else begin
                            pc_d    = eff_target;
                            take_ev = 1'b1;
                            if (FLUSH_CYCLES > 0) begin
                                state_d = FLUSH;
                                cnt_d   = FLUSH_LOAD;
                            end
                        end
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            // Stall does not extend the flush window; the killed slots are fixed.
            FLUSH: begin
                if (cnt_q == 4'd0) state_d = RUN;
                else               cnt_d   = cnt_q - 4'd1;
            end
            TRAP:    state_d = TRAP;
            default: state_d = BOOT;
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_valid = (state_q == RUN);
    assign bus.flush       = (state_q == FLUSH) || (state_q == TRAP);
    assign bus.misaligned  = mis_q;

`ifdef PC_BRANCH_STATS_EN
    logic [31:0] taken_count_q;
    logic [7:0]  trap_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_count_q <= 32'd0;
            trap_count_q  <= 8'd0;
        end else begin
            if (take_ev) taken_count_q <= taken_count_q + 32'd1;
            if (trap_ev && trap_count_q != 8'hFF) trap_count_q <= trap_count_q + 8'd1;
        end
    end

    assign bus.taken_count = taken_count_q;
    assign bus.trap_count  = trap_count_q;
`else
    logic unused_ev;
    assign unused_ev = take_ev ^ trap_ev;
`endif

endmodule
